// File: rtl/mram_pkg.sv
// Shared types and sizes for the MRAM access sequencer and its arbiter.
package mram_pkg;

  localparam int MRAM_ADDR_W = 20;
  localparam int MRAM_DATA_W = 16;
  localparam int N_REQ       = 2;

  // Access phases of the sequencer
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    HOLD
  } mram_state_t;

  // One-hot request vector for a requester index
  function automatic logic [N_REQ-1:0] portOneHot(input logic idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Zero the bytes whose byte enable is clear
  function automatic logic [MRAM_DATA_W-1:0] maskBytes(input logic [MRAM_DATA_W-1:0] data,
                                                       input logic [1:0] be);
    return {(be[1] ? data[15:8] : 8'h00), (be[0] ? data[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/mram_rr_arbiter.sv
// Two-requester grant selection for the MRAM sequencer.
// Default build: round-robin, the port other than the last granted wins a tie.
// With MRAM_SEQ_FIXED_PRIO_EN defined: port 0 has strict priority, no pointer.
module mram_rr_arbiter
  import mram_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_accept,
  output logic             o_grant
);

`ifdef MRAM_SEQ_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_accept};

  // Port 0 wins whenever it asks
  always_comb begin
    o_grant = ~i_req[0];
  end
`else
  logic r_last;

  // Remember which port was granted last; reset behaves as if port 1 was
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_grant;
    end
  end

  // A lone request always wins; a tie goes to the port not granted last
  always_comb begin
    if (i_req[0] && i_req[1]) begin
      o_grant = ~r_last;
    end else begin
      o_grant = ~i_req[0];
    end
  end
`endif

endmodule

// File: rtl/mram_access_sequencer.sv
// Sequences single MRAM read/write accesses (setup, strobe, hold) for two
// requesters. Define MRAM_SEQ_FIXED_PRIO_EN for fixed port-0 priority
// instead of round-robin arbitration.
module mram_access_sequencer
  import mram_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 4,
  parameter int RD_CYC    = 3
) (
  input  logic                         FPGA_clk,
  input  logic                         FPGA_rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*MRAM_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*MRAM_DATA_W-1:0] req_wdata,
  input  logic [2*N_REQ-1:0]           req_be,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             done,
  output logic [MRAM_DATA_W-1:0]       rd_data,
  output logic                         busy,
  output logic [MRAM_ADDR_W-1:0]       addr_to_MRAM,
  output logic [MRAM_DATA_W-1:0]       data_to_MRAM,
  input  logic [MRAM_DATA_W-1:0]       data_from_MRAM,
  output logic                         data_oe,
  output logic                         chip_en,
  output logic                         write_en,
  output logic                         out_en,
  output logic                         lower_byte_en,
  output logic                         upper_byte_en
);

  localparam int MAX_CYC = (SETUP_CYC > WR_CYC)
                         ? ((SETUP_CYC > RD_CYC) ? SETUP_CYC : RD_CYC)
                         : ((WR_CYC > RD_CYC) ? WR_CYC : RD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mram_state_t            r_state;
  mram_state_t            w_nextState;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_grant;
  logic                   r_gnt;
  logic                   r_we;
  logic [MRAM_ADDR_W-1:0] r_addr;
  logic [MRAM_DATA_W-1:0] r_wdata;
  logic [1:0]             r_be;
  logic [MRAM_DATA_W-1:0] r_rdData;

  assign w_accept = (r_state == IDLE) && (|req);

  mram_rr_arbiter u_arb (
    .i_clk    (FPGA_clk),
    .i_rst    (FPGA_rst),
    .i_req    (req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // State register and per-phase cycle counter (cleared on every phase change)
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (w_nextState == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Latch the granted requester's command at the accepting edge
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_gnt   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_gnt   <= w_grant;
      r_we    <= req_we[w_grant];
      r_addr  <= w_grant ? req_addr[2*MRAM_ADDR_W-1:MRAM_ADDR_W] : req_addr[MRAM_ADDR_W-1:0];
      r_wdata <= w_grant ? req_wdata[2*MRAM_DATA_W-1:MRAM_DATA_W] : req_wdata[MRAM_DATA_W-1:0];
      r_be    <= w_grant ? req_be[3:2] : req_be[1:0];
    end
  end

  // Capture read data on the last out_en cycle, dropping disabled bytes
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_rdData <= '0;
    end else if ((r_state == READ) && w_last) begin
      r_rdData <= maskBytes(data_from_MRAM, r_be);
    end
  end

  // Next state and MRAM strobes decoded from the current phase
  always_comb begin
    w_nextState   = r_state;
    w_last        = 1'b0;
    chip_en       = 1'b1;
    write_en      = 1'b1;
    out_en        = 1'b1;
    lower_byte_en = 1'b1;
    upper_byte_en = 1'b1;
    data_oe       = 1'b0;
    ack           = '0;
    done          = '0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_last        = (r_cnt == CNT_W'(SETUP_CYC - 1));
        chip_en       = 1'b0;
        lower_byte_en = ~r_be[0];
        upper_byte_en = ~r_be[1];
        data_oe       = r_we;
        if (r_cnt == '0) begin
          ack = portOneHot(r_gnt);
        end
        if (w_last) begin
          w_nextState = r_we ? WRITE : READ;
        end
      end
      WRITE: begin
        w_last        = (r_cnt == CNT_W'(WR_CYC - 1));
        chip_en       = 1'b0;
        write_en      = 1'b0;
        lower_byte_en = ~r_be[0];
        upper_byte_en = ~r_be[1];
        data_oe       = 1'b1;
        if (w_last) begin
          w_nextState = HOLD;
        end
      end
      READ: begin
        w_last        = (r_cnt == CNT_W'(RD_CYC - 1));
        chip_en       = 1'b0;
        out_en        = 1'b0;
        lower_byte_en = ~r_be[0];
        upper_byte_en = ~r_be[1];
        if (w_last) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        data_oe     = r_we;
        done        = portOneHot(r_gnt);
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign addr_to_MRAM = r_addr;
  assign data_to_MRAM = r_wdata;
  assign rd_data      = r_rdData;

endmodule
